// File: rtl/u111_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : u111_bus_arbiter                                              |
// | Purpose  : 68040 BR/BG/BB local-bus arbiter between CPU and PCI DMA,     |
// |            bus parked on the CPU. Optional macro ARB_TENURE_LIMIT_EN.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module u111_bus_arbiter #(
  parameter int GNT_TIMEOUT = 16,
  parameter int MAX_TENURE  = 64
) (
  input  logic CLK40,
  input  logic RESETn,
  input  logic BR_CPUn,
  input  logic BB_CPUn,
  input  logic LOCKn,
  input  logic TS_CPUn,
  input  logic BR_PCIn,
  input  logic BB_PCIn,
  output logic BG_CPUn,
  output logic BG_PCIn,
  output logic BGn,
  output logic PCI_OWNER,
  output logic GNT_TOUT
);

  localparam int c_TOUT_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
  localparam logic [c_TOUT_W-1:0] c_TOUT_LOAD = c_TOUT_W'(GNT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_CPU_OWN = 3'd0,
    S_CPU_REL = 3'd1,
    S_PCI_GNT = 3'd2,
    S_PCI_OWN = 3'd3,
    S_PCI_REL = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_TOUT_W-1:0]   r_tout_cnt;
  logic [c_TOUT_W-1:0]   w_tout_nxt;
  logic                  r_bb_seen;
  logic                  w_bb_seen_nxt;
  logic                  w_gnt_tout_nxt;
  logic                  w_tenure_expired;

  logic r_bg_cpun;
  logic r_bg_pcin;
  logic r_bgn;
  logic r_pci_owner;
  logic r_gnt_tout;

`ifdef ARB_TENURE_LIMIT_EN
  localparam int c_TEN_W = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
  localparam logic [c_TEN_W-1:0] c_TEN_LAST = c_TEN_W'(MAX_TENURE - 1);

  logic [c_TEN_W-1:0] r_tenure;

  assign w_tenure_expired = (r_tenure == c_TEN_LAST) && !BR_CPUn;

  // Saturates at the limit so a late CPU request still forces the release.
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      r_tenure <= '0;
    end else if ((r_state != S_PCI_GNT) && (w_state_nxt == S_PCI_GNT)) begin
      r_tenure <= '0;
    end else if ((r_state == S_PCI_OWN) && (r_tenure != c_TEN_LAST)) begin
      r_tenure <= r_tenure + c_TEN_W'(1);
    end
  end
`else
  logic w_unused_tenure;

  assign w_tenure_expired = 1'b0;
  assign w_unused_tenure  = BR_CPUn | (MAX_TENURE < 2);
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_tout_nxt     = r_tout_cnt;
    w_bb_seen_nxt  = 1'b0;
    w_gnt_tout_nxt = 1'b0;
    case (r_state)
      S_CPU_OWN: begin
        if (!BR_PCIn && LOCKn && TS_CPUn) begin
          w_state_nxt = S_CPU_REL;
        end
      end
      S_CPU_REL: begin
        // CPU must be seen idle on two consecutive samples before PCI is granted.
        if (BR_PCIn) begin
          w_state_nxt = S_CPU_OWN;
        end else if (BB_CPUn && r_bb_seen) begin
          w_state_nxt = S_PCI_GNT;
          w_tout_nxt  = c_TOUT_LOAD;
        end else begin
          w_bb_seen_nxt = BB_CPUn;
        end
      end
      S_PCI_GNT: begin
        if (!BB_PCIn) begin
          w_state_nxt = S_PCI_OWN;
        end else if (r_tout_cnt == '0) begin
          w_state_nxt    = S_CPU_OWN;
          w_gnt_tout_nxt = 1'b1;
        end else begin
          w_tout_nxt = r_tout_cnt - c_TOUT_W'(1);
        end
      end
      S_PCI_OWN: begin
        if (BR_PCIn || w_tenure_expired) begin
          w_state_nxt = S_PCI_REL;
        end
      end
      S_PCI_REL: begin
        if (BB_PCIn) begin
          w_state_nxt = S_CPU_OWN;
        end
      end
      default: begin
        w_state_nxt = S_CPU_OWN;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      r_state     <= S_CPU_OWN;
      r_tout_cnt  <= '0;
      r_bb_seen   <= 1'b0;
      r_bg_cpun   <= 1'b0;
      r_bg_pcin   <= 1'b1;
      r_bgn       <= 1'b0;
      r_pci_owner <= 1'b0;
      r_gnt_tout  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tout_cnt  <= w_tout_nxt;
      r_bb_seen   <= w_bb_seen_nxt;
      r_bg_cpun   <= (w_state_nxt != S_CPU_OWN);
      r_bg_pcin   <= !((w_state_nxt == S_PCI_GNT) || (w_state_nxt == S_PCI_OWN));
      r_bgn       <= (w_state_nxt != S_CPU_OWN);
      r_pci_owner <= (w_state_nxt == S_PCI_OWN);
      r_gnt_tout  <= w_gnt_tout_nxt;
    end
  end

  assign BG_CPUn   = r_bg_cpun;
  assign BG_PCIn   = r_bg_pcin;
  assign BGn       = r_bgn;
  assign PCI_OWNER = r_pci_owner;
  assign GNT_TOUT  = r_gnt_tout;

endmodule
`default_nettype wire
